reg_bus_mover: RTL and testbench
================================

# reg_bus_mover

Register-unit transfer sequencer for the relay machine: the read side of the register bank. It drives one register onto the shared data bus via its select line, waits a fixed relay-settle interval, pulses the destination's load line, then releases the bus. It owns the register storage (NUM_REG × WIDTH), accepts MOV requests over a valid/ready handshake, and accepts direct external loads while idle. It sits between the instruction sequencer and the register/bus fabric.

## Interface
- WIDTH, 8, register and bus width in bits
- NUM_REG, 8, number of registers; index width IW = $clog2(NUM_REG), minimum 1
- SETTLE, 2, cycles the bus is held selected before load; legal range 1..15
- clk  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  MOV request present
- req_ready  out  1  block can accept a request this cycle
- req_src  in  IW  source register index
- req_dst  in  IW  destination register index
- ext_load  in  1  direct write of ext_data into register ext_idx
- ext_idx  in  IW  external write index
- ext_data  in  WIDTH  external write data
- sel  out  NUM_REG  one-hot bus select (source enable)
- load  out  NUM_REG  one-hot load strobe (destination)
- bus  out  WIDTH  data bus value
- done  out  1  one-cycle pulse at MOV completion
- err  out  1  one-cycle pulse with done when src or dst index ≥ NUM_REG
- reg_q  out  NUM_REG*WIDTH  flattened register contents, reg i at [i*WIDTH +: WIDTH]

## Operation
- States: IDLE, SEL, LOAD, RELEASE.
- IDLE: req_ready = !ext_load. ext_load takes priority: reg[ext_idx] ← ext_data at the edge, and no request is accepted that cycle. If req_valid && req_ready, src/dst are latched and the FSM goes to SEL with cnt = SETTLE-1.
- SEL: sel[src] = 1, load = 0. When cnt == 0 → LOAD, otherwise cnt decrements.
- LOAD: sel[src] = 1, load[dst] = 1 for exactly one cycle. reg[dst] ← bus at the closing edge. Then → RELEASE.
- RELEASE: sel = 0, load = 0, done = 1 (err = 1 if an index was out of range). Then → IDLE.
- bus = reg[src] whenever sel is nonzero, otherwise all zeros (pulled-down bus).
- src == dst is legal: the full sequence runs and the value is unchanged.
- Out-of-range index: the request is accepted. The out-of-range side drives no sel/load bit, and bus = 0 if src is invalid. If only src is invalid, a valid dst loads 0. Timing is unchanged.
- ext_load outside IDLE is ignored, with no side effects.
- sel and load are never multi-hot. No load bit is asserted without its sel phase having preceded it.

## Timing
- Reset values: all registers 0, state IDLE, sel 0, load 0, bus 0, done 0, err 0, req_ready 1 (subject to ext_load).
- Reset asserted mid-transfer: sel/load drop immediately (async) and no partial load occurs.
- Request accepted at edge E0:
  - SEL occupies cycles 1..SETTLE.
  - LOAD occupies cycle SETTLE+1; reg_q shows the new dst value from cycle SETTLE+2.
  - RELEASE/done is in cycle SETTLE+2.
  - req_ready returns in cycle SETTLE+3.
- Total occupancy per MOV: SETTLE+2 cycles. Back-to-back throughput: one MOV per SETTLE+3 cycles.
- ext_load latency: 1 cycle (visible on reg_q the next cycle).
- All outputs are registered state or decoded from registered state only. No input-to-output combinational path except req_ready from ext_load.

## Structure
- Package reg_unit_pkg holds:
  - the state enum (IDLE, SEL, LOAD, RELEASE)
  - default WIDTH/NUM_REG/SETTLE constants
  - a one-hot decode function returning 0 for out-of-range indices
- Sub-module reg_slot: one WIDTH-bit storage register with async active-low clear, load enable and data input. reg_bus_mover instantiates it NUM_REG times in a generate loop; the write mux (ext vs bus) sits in the parent.

## Test plan
- Reset then ext_load regs 0..7 with 0x10..0x17 → reg_q matches; sel/load/bus 0 throughout.
- MOV src=2, dst=5, SETTLE=2:
  - sel=0x04 and bus=0x12 for 3 cycles
  - load=0x20 in the 3rd of those cycles
  - done in cycle 4; reg5 = 0x12; req_ready low cycles 1–4
- MOV src=3, dst=3 → same timing; reg3 stays 0x13; done pulses once.
- ext_load and req_valid asserted together in IDLE → ext write happens, req_ready=0, MOV starts the following cycle.
- NUM_REG=6, MOV src=7, dst=1 → no sel bit, bus=0, load=0x02, reg1=0, done and err pulse together.
- Assert reset_n low during LOAD → sel/load go 0 asynchronously; after release all regs 0, state IDLE, req_ready 1.

Source files
------------

// File: rtl/reg_unit_pkg.sv
// -----------------------------------------------------------------------------
// reg_unit_pkg
// Shared definitions for the relay-machine register unit: the transfer FSM
// state encoding, default geometry constants and a bounded one-hot decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package reg_unit_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REG = 8;
    localparam int DEF_SETTLE  = 2;

    // Upper bound on register count that the decoder can address.
    localparam int MAX_REG     = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEL     = 2'd1,
        S_LOAD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // One-hot decode of idx; an index at or beyond count yields all zeros so
    // an out-of-range register never drives a select or load line.
    function automatic logic [MAX_REG-1:0] oneHotDecode(input int idx, input int count);
        logic [MAX_REG-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_REG; i++) begin
            v[i] = (i == idx) && (idx < count);
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_slot.sv
// -----------------------------------------------------------------------------
// reg_slot
// One WIDTH-bit storage register of the register bank.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low clear
//   i_en     - load enable
//   i_d      - data to store when enabled
//   o_q      - stored value
// -----------------------------------------------------------------------------
module reg_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Storage register: cleared by reset, otherwise holds until enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_bus_mover.sv
// -----------------------------------------------------------------------------
// reg_bus_mover
// Register-bank read side and transfer sequencer. A MOV request selects the
// source register onto the bus, holds it for SETTLE cycles so the relays can
// settle, strobes the destination load line for one cycle, then releases the
// bus and pulses done. While idle, ext_load writes a register directly.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   req_valid/req_ready - MOV request handshake
//   req_src, req_dst    - source / destination register indices
//   ext_load, ext_idx,
//   ext_data            - direct register write (idle only, beats requests)
//   sel, load           - one-hot source select / destination load strobe
//   bus                 - data bus (zero when nothing is selected)
//   done, err           - completion pulse, out-of-range index flag
//   reg_q               - flattened register contents, reg i at [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module reg_bus_mover
    import reg_unit_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  NUM_REG = DEF_NUM_REG,
    parameter int  SETTLE  = DEF_SETTLE,
    localparam int IW      = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [IW-1:0]            req_src,
    input  logic [IW-1:0]            req_dst,
    input  logic                     ext_load,
    input  logic [IW-1:0]            ext_idx,
    input  logic [WIDTH-1:0]         ext_data,
    output logic [NUM_REG-1:0]       sel,
    output logic [NUM_REG-1:0]       load,
    output logic [WIDTH-1:0]         bus,
    output logic                     done,
    output logic                     err,
    output logic [NUM_REG*WIDTH-1:0] reg_q
);

    state_t             r_state;
    state_t             w_nextState;
    logic [3:0]         r_cnt;
    logic [IW-1:0]      r_src;
    logic [IW-1:0]      r_dst;
    logic               w_accept;
    logic               w_extWrite;
    logic [NUM_REG-1:0] w_srcHot;
    logic [NUM_REG-1:0] w_dstHot;
    logic [NUM_REG-1:0] w_extHot;
    logic [WIDTH-1:0]   w_wrData;
    logic [WIDTH-1:0]   w_regs [NUM_REG];

    assign w_srcHot = NUM_REG'(oneHotDecode(int'(r_src), NUM_REG));
    assign w_dstHot = NUM_REG'(oneHotDecode(int'(r_dst), NUM_REG));
    assign w_extHot = NUM_REG'(oneHotDecode(int'(ext_idx), NUM_REG));

    // Next-state and output decode. Every output comes from registered state
    // except req_ready, which must drop in the same cycle as ext_load so a
    // direct write and a request acceptance never share an edge.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_extWrite  = 1'b0;
        req_ready   = 1'b0;
        sel         = '0;
        load        = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready  = !ext_load;
                w_extWrite = ext_load;
                if (req_valid && !ext_load) begin
                    w_accept    = 1'b1;
                    w_nextState = S_SEL;
                end
            end
            S_SEL: begin
                sel = w_srcHot;
                if (r_cnt == 4'd0) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                sel         = w_srcHot;
                load        = w_dstHot;
                w_nextState = S_RELEASE;
            end
            S_RELEASE: begin
                done        = 1'b1;
                err         = !(|w_srcHot) || !(|w_dstHot);
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Pulled-down bus: OR of the selected registers, so an invalid source
    // (no sel bit) reads as zero.
    always_comb begin
        bus = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (sel[i]) begin
                bus = bus | w_regs[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request latch and settle counter; the counter loads SETTLE-1 so the
    // SEL phase spans exactly SETTLE cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src <= '0;
            r_dst <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_src <= req_src;
            r_dst <= req_dst;
            r_cnt <= 4'(SETTLE - 1);
        end else if ((r_state == S_SEL) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Direct writes only happen in IDLE, when no load bit can be active.
    assign w_wrData = w_extWrite ? ext_data : bus;

    for (genvar i = 0; i < NUM_REG; i++) begin : g_slot
        logic w_en;
        assign w_en = (w_extWrite && w_extHot[i]) || load[i];

        reg_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .i_en    (w_en),
            .i_d     (w_wrData),
            .o_q     (w_regs[i])
        );

        assign reg_q[i*WIDTH +: WIDTH] = w_regs[i];
    end

endmodule

// File: tb/tb_reg_bus_mover.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_mover
// Scoreboard bench for reg_bus_mover. Instance A uses 8 registers, instance B
// uses 6 so that index 6/7 are out of range. Stimulus pushes the expected
// per-cycle bus activity of each MOV into a queue; a monitor per instance pops
// one entry for every busy cycle and checks sel/load/bus/done/err.
// -----------------------------------------------------------------------------
module tb_reg_bus_mover;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] load;
        logic [7:0] bus;
        logic       done;
        logic       err;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_reqValid, a_reqReady, a_extLoad, a_done, a_err;
    logic [2:0]  a_src, a_dst, a_extIdx;
    logic [7:0]  a_extData, a_sel, a_load, a_bus;
    logic [63:0] a_regQ;

    logic        b_reqValid, b_reqReady, b_extLoad, b_done, b_err;
    logic [2:0]  b_src, b_dst, b_extIdx;
    logic [7:0]  b_extData, b_bus;
    logic [5:0]  b_sel, b_load;
    logic [47:0] b_regQ;

    int   checks = 0;
    int   errors = 0;
    int   doneA  = 0;
    int   doneB  = 0;
    cyc_t qA[$];
    cyc_t qB[$];
    cyc_t eA, eB;

    reg_bus_mover #(.WIDTH(8), .NUM_REG(8), .SETTLE(2)) dutA (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (a_reqValid),
        .req_ready (a_reqReady),
        .req_src   (a_src),
        .req_dst   (a_dst),
        .ext_load  (a_extLoad),
        .ext_idx   (a_extIdx),
        .ext_data  (a_extData),
        .sel       (a_sel),
        .load      (a_load),
        .bus       (a_bus),
        .done      (a_done),
        .err       (a_err),
        .reg_q     (a_regQ)
    );

    reg_bus_mover #(.WIDTH(8), .NUM_REG(6), .SETTLE(2)) dutB (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (b_reqValid),
        .req_ready (b_reqReady),
        .req_src   (b_src),
        .req_dst   (b_dst),
        .ext_load  (b_extLoad),
        .ext_idx   (b_extIdx),
        .ext_data  (b_extData),
        .sel       (b_sel),
        .load      (b_load),
        .bus       (b_bus),
        .done      (b_done),
        .err       (b_err),
        .reg_q     (b_regQ)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkCyc(input string tag, input cyc_t e, input logic [7:0] s,
                            input logic [7:0] l, input logic [7:0] b,
                            input logic d, input logic er);
        checkVal({tag, " sel"},  64'(s),  64'(e.sel));
        checkVal({tag, " load"}, 64'(l),  64'(e.load));
        checkVal({tag, " bus"},  64'(b),  64'(e.bus));
        checkVal({tag, " done"}, 64'(d),  64'(e.done));
        checkVal({tag, " err"},  64'(er), 64'(e.err));
    endtask

    task automatic pushCyc(input bit toB, input logic [7:0] s, input logic [7:0] l,
                           input logic [7:0] b, input logic d, input logic er);
        cyc_t c;
        c.sel  = s;
        c.load = l;
        c.bus  = b;
        c.done = d;
        c.err  = er;
        if (toB) qB.push_back(c);
        else     qA.push_back(c);
    endtask

    // Expected activity of one MOV with SETTLE=2: two SEL cycles, one LOAD
    // cycle, then the RELEASE cycle carrying done/err.
    task automatic pushMov(input bit toB, input logic [7:0] s, input logic [7:0] l,
                           input logic [7:0] b, input logic er);
        pushCyc(toB, s, 8'h00, b, 1'b0, 1'b0);
        pushCyc(toB, s, 8'h00, b, 1'b0, 1'b0);
        pushCyc(toB, s, l,     b, 1'b0, 1'b0);
        pushCyc(toB, 8'h00, 8'h00, 8'h00, 1'b1, er);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit toB, input logic [2:0] src, input logic [2:0] dst);
        if (toB) begin
            b_reqValid = 1'b1; b_src = src; b_dst = dst;
        end else begin
            a_reqValid = 1'b1; a_src = src; a_dst = dst;
        end
        tick();
        a_reqValid = 1'b0;
        b_reqValid = 1'b0;
        repeat (5) tick();
    endtask

    // Monitor A: busy cycles consume scoreboard entries, idle cycles must be quiet.
    always @(negedge clk) begin
        if (reset_n) begin
            if (a_done) doneA++;
            if (!a_reqReady && !a_extLoad) begin
                if (qA.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL A busy cycle with empty scoreboard sel=0x%0h load=0x%0h", a_sel, a_load);
                end else begin
                    eA = qA.pop_front();
                    checkCyc("A cycle", eA, a_sel, a_load, a_bus, a_done, a_err);
                end
            end else begin
                checkVal("A idle outputs", 64'({a_sel, a_load, a_bus, a_done, a_err}), 64'd0);
            end
        end
    end

    // Monitor B: same scheme for the 6-register instance.
    always @(negedge clk) begin
        if (reset_n) begin
            if (b_done) doneB++;
            if (!b_reqReady && !b_extLoad) begin
                if (qB.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL B busy cycle with empty scoreboard sel=0x%0h load=0x%0h", b_sel, b_load);
                end else begin
                    eB = qB.pop_front();
                    checkCyc("B cycle", eB, 8'(b_sel), 8'(b_load), b_bus, b_done, b_err);
                end
            end else begin
                checkVal("B idle outputs", 64'({b_sel, b_load, b_bus, b_done, b_err}), 64'd0);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        a_reqValid = 1'b0; a_src = '0; a_dst = '0;
        a_extLoad  = 1'b0; a_extIdx = '0; a_extData = '0;
        b_reqValid = 1'b0; b_src = '0; b_dst = '0;
        b_extLoad  = 1'b0; b_extIdx = '0; b_extData = '0;
        repeat (3) tick();

        checkVal("reset A reg_q", a_regQ, 64'd0);
        checkVal("reset A outputs", 64'({a_sel, a_load, a_bus, a_done, a_err}), 64'd0);
        checkVal("reset B reg_q", 64'(b_regQ), 64'd0);
        reset_n = 1'b1;
        tick();
        checkVal("reset A req_ready", 64'(a_reqReady), 64'd1);
        checkVal("reset B req_ready", 64'(b_reqReady), 64'd1);

        // Direct loads: A gets 0x10..0x17, B gets 0x20..0x25.
        for (int i = 0; i < 8; i++) begin
            a_extLoad = 1'b1; a_extIdx = 3'(i); a_extData = 8'(8'h10 + i);
            b_extLoad = (i < 6); b_extIdx = 3'(i); b_extData = 8'(8'h20 + i);
            tick();
        end
        a_extLoad = 1'b0;
        b_extLoad = 1'b0;
        tick();
        checkVal("ext load A reg_q", a_regQ, 64'h1716151413121110);
        checkVal("ext load B reg_q", 64'(b_regQ), 64'h252423222120);

        // MOV 2 -> 5.
        pushMov(1'b0, 8'h04, 8'h20, 8'h12, 1'b0);
        applyStimulus(1'b0, 3'd2, 3'd5);
        checkVal("mov 2->5 reg_q", a_regQ, 64'h1716121413121110);

        // MOV 3 -> 3: value unchanged.
        pushMov(1'b0, 8'h08, 8'h08, 8'h13, 1'b0);
        applyStimulus(1'b0, 3'd3, 3'd3);
        checkVal("mov 3->3 reg_q", a_regQ, 64'h1716121413121110);

        // ext_load wins over a simultaneous request; the MOV then copies the
        // freshly written reg6 into reg0.
        pushMov(1'b0, 8'h40, 8'h01, 8'hA6, 1'b0);
        a_extLoad = 1'b1; a_extIdx = 3'd6; a_extData = 8'hA6;
        a_reqValid = 1'b1; a_src = 3'd6; a_dst = 3'd0;
        #1;
        checkVal("ext+req req_ready", 64'(a_reqReady), 64'd0);
        tick();
        a_extLoad = 1'b0;
        checkVal("ext+req reg6 written", 64'(a_regQ[55:48]), 64'hA6);
        tick();
        a_reqValid = 1'b0;
        repeat (5) tick();
        checkVal("ext+req mov reg_q", a_regQ, 64'h17A61214131211A6);
        checkVal("A done count", 64'(doneA), 64'd3);

        // B: invalid source, valid destination loads zero.
        pushMov(1'b1, 8'h00, 8'h02, 8'h00, 1'b1);
        applyStimulus(1'b1, 3'd7, 3'd1);
        checkVal("B mov 7->1 reg_q", 64'(b_regQ), 64'h252423222020 & 64'hFFFFFFFF00FF);

        // B: valid source, invalid destination changes nothing.
        pushMov(1'b1, 8'h01, 8'h00, 8'h20, 1'b1);
        applyStimulus(1'b1, 3'd0, 3'd6);
        checkVal("B mov 0->6 reg_q", 64'(b_regQ), 64'h252423220020);

        // B: ordinary MOV clears err again.
        pushMov(1'b1, 8'h10, 8'h04, 8'h24, 1'b0);
        applyStimulus(1'b1, 3'd4, 3'd2);
        checkVal("B mov 4->2 reg_q", 64'(b_regQ), 64'h252423240020);
        checkVal("B done count", 64'(doneB), 64'd3);

        // Reset during the LOAD cycle of MOV 1 -> 7 on A.
        pushCyc(1'b0, 8'h02, 8'h00, 8'h11, 1'b0, 1'b0);
        pushCyc(1'b0, 8'h02, 8'h00, 8'h11, 1'b0, 1'b0);
        a_reqValid = 1'b1; a_src = 3'd1; a_dst = 3'd7;
        tick();
        a_reqValid = 1'b0;
        tick();
        tick();
        #1;
        checkVal("LOAD phase before reset", 64'(a_load), 64'h80);
        reset_n = 1'b0;
        #1;
        checkVal("async reset sel/load/bus", 64'({a_sel, a_load, a_bus}), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        checkVal("post reset A reg_q", a_regQ, 64'd0);
        checkVal("post reset A req_ready", 64'(a_reqReady), 64'd1);

        repeat (2) tick();
        checkVal("A scoreboard drained", 64'(qA.size()), 64'd0);
        checkVal("B scoreboard drained", 64'(qB.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
